// File: rtl/diffeq_datapath.sv
// diffeq_datapath
//   Datapath of the differential-equation solver. Holds x, dx, u, a, y in
//   signed Q(W-FRAC).FRAC and, once per loop iteration, evaluates
//     x1 = x + dx;  u1 = u - 3*x*u*dx - 3*y*dx;  y1 = y + u*dx
//   as three multiply steps (COMPUTE_1..3) on one shared radix-2 shift-add
//   multiplier, followed by a single commit cycle (COMPUTE_4).
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low
//   state[2:0]     controller state: 0 IDLE,1 READ,2..5 COMPUTE_1..4,6 DONE
//   load_x/dx/u/a  capture data_in while in READ (priority x>dx>a>u)
//   data_in[W-1:0] operand value
//   compute_done   one-cycle pulse once a COMPUTE_1..3 result is registered
//   continue_while combinational signed (x1 < a)
//   x_out,y_out,u_out current x, y, u
module diffeq_datapath #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   state,
  input  logic         load_x,
  input  logic         load_dx,
  input  logic         load_u,
  input  logic         load_a,
  input  logic [W-1:0] data_in,
  output logic         compute_done,
  output logic         continue_while,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] u_out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_C1   = 3'd2,
    ST_C2   = 3'd3,
    ST_C3   = 3'd4,
    ST_C4   = 3'd5,
    ST_DONE = 3'd6
  } ctrl_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_BUSY,
    ENG_PULSE
  } eng_t;

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  ctrl_t st;
  eng_t  eng_q, eng_d;

  logic signed [W-1:0] x, dx, u, a, y, x1, t1, t2, t3;
  logic [2:0]          prev_state;
  logic                seen;

  logic [2*W-1:0] acc, mcand, acc_nxt;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic                entry, is_mul, start, last_iter;
  logic signed [W-1:0] op_a, op_b;
  logic [W-1:0]        mag_a, mag_b;
  logic [W-1:0]        res, res3;

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    return v[W-1] ? W'(-v) : W'(v);
  endfunction

  assign st = ctrl_t'(state);

  // `seen` suppresses entry detection on the first cycle after reset, so a
  // state already held through reset is not treated as a new step.
  assign entry  = seen && (state != prev_state);
  assign is_mul = (st == ST_C1) || (st == ST_C2) || (st == ST_C3);
  assign start  = entry && is_mul;

  always_comb begin
    op_a = u;
    op_b = dx;
    case (st)
      ST_C2:   begin op_a = x; op_b = t1; end
      ST_C3:   begin op_a = y; op_b = dx; end
      default: ;
    endcase
  end

  assign mag_a   = mag(op_a);
  assign mag_b   = mag(op_b);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Sign restore, arithmetic >>>FRAC and truncation to W collapse into one
  // slice because FRAC+W never exceeds the 2W product width.
  assign res  = W'((neg ? -acc_nxt : acc_nxt) >> FRAC);
  assign res3 = (res << 1) + res;

  assign last_iter = (eng_q == ENG_BUSY) && !entry && is_mul && (cnt == LAST);

  always_comb begin
    eng_d = eng_q;
    if (start) begin
      eng_d = ENG_BUSY;
    end else begin
      case (eng_q)
        ENG_BUSY: begin
          if (entry || !is_mul) eng_d = ENG_IDLE;
          else if (cnt == LAST) eng_d = ENG_PULSE;
        end
        default: eng_d = ENG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) eng_q <= ENG_IDLE;
    else        eng_q <= eng_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x          <= '0;
      dx         <= '0;
      u          <= '0;
      a          <= '0;
      y          <= '0;
      x1         <= '0;
      t1         <= '0;
      t2         <= '0;
      t3         <= '0;
      prev_state <= '0;
      seen       <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
    end else begin
      prev_state <= state;
      seen       <= 1'b1;

      if (st == ST_READ) begin
        if (load_x) begin
          x <= data_in;
          y <= '0;
        end else if (load_dx) begin
          dx <= data_in;
        end else if (load_a) begin
          a <= data_in;
        end else if (load_u) begin
          u <= data_in;
        end
      end

      if (st == ST_C4) begin
        u <= u - t2 - t3;
        y <= y + t1;
        x <= x1;
      end

      if (start && st == ST_C1) x1 <= x + dx;

      // The start cycle already performs the first shift-add iteration so
      // that the W-th iteration lands on the W-th cycle of the state.
      if (start) begin
        acc    <= mag_b[0] ? (2*W)'(mag_a) : '0;
        mcand  <= (2*W)'(mag_a) << 1;
        mplier <= mag_b >> 1;
        cnt    <= CW'(1);
        neg    <= op_a[W-1] ^ op_b[W-1];
      end else if (eng_q == ENG_BUSY) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end

      if (last_iter) begin
        case (st)
          ST_C1:   t1 <= res;
          ST_C2:   t2 <= res3;
          ST_C3:   t3 <= res3;
          default: ;
        endcase
      end
    end
  end

  assign compute_done   = (eng_q == ENG_PULSE);
  assign continue_while = (x1 < a);
  assign x_out = x;
  assign y_out = y;
  assign u_out = u;

endmodule

// File: tb/tb_diffeq_datapath.sv
module tb_diffeq_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic        load_x, load_dx, load_u, load_a;
  logic [15:0] data_in;
  logic        compute_done, continue_while;
  logic [15:0] x_out, y_out, u_out;

  int n_cmp = 0;
  int n_err = 0;

  diffeq_datapath #(.W(16), .FRAC(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .load_x         (load_x),
    .load_dx        (load_dx),
    .load_u         (load_u),
    .load_a         (load_a),
    .data_in        (data_in),
    .compute_done   (compute_done),
    .continue_while (continue_while),
    .x_out          (x_out),
    .y_out          (y_out),
    .u_out          (u_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] sel, input logic [15:0] val);
    state   = 3'd1;
    load_x  = sel[3];
    load_dx = sel[2];
    load_a  = sel[1];
    load_u  = sel[0];
    data_in = val;
    step();
    {load_x, load_dx, load_a, load_u} = '0;
  endtask

  // Caller has just set a compute state; pulse must appear only in cycle 17.
  task automatic wait_done(input string tag);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("%s_cyc%0d", tag, i + 1), {15'd0, compute_done}, {15'd0, (i == 16)});
    end
  endtask

  task automatic iterate(input logic [2:0] after4);
    state = 3'd2; wait_done("c1");
    state = 3'd3; wait_done("c2");
    state = 3'd4; wait_done("c3");
    state = 3'd5;
    step();
    chk("c4_no_pulse", {15'd0, compute_done}, 16'd0);
    state = after4;
  endtask

  initial begin
    reset = 1'b0;
    state = 3'd0;
    {load_x, load_dx, load_a, load_u} = '0;
    data_in = '0;
    step();
    step();
    chk("rst_x", x_out, 16'h0000);
    chk("rst_y", y_out, 16'h0000);
    chk("rst_u", u_out, 16'h0000);
    chk("rst_done", {15'd0, compute_done}, 16'd0);
    chk("rst_cw", {15'd0, continue_while}, 16'd0);
    reset = 1'b1;
    step();

    // Test 1: loads
    load(4'b1000, 16'h0000);
    load(4'b0100, 16'h0080);
    load(4'b0001, 16'h0100);
    load(4'b0010, 16'h0100);
    state = 3'd0;
    chk("ld_x", x_out, 16'h0000);
    chk("ld_u", u_out, 16'h0100);
    chk("ld_y", y_out, 16'h0000);
    chk("ld_cw", {15'd0, continue_while}, 16'd1);

    // Test 2: pulse timing of a lone COMPUTE_1 step, exactly one cycle
    step();
    state = 3'd2;
    wait_done("t2");
    step();
    chk("t2_one_cycle", {15'd0, compute_done}, 16'd0);
    state = 3'd6;
    step();

    // Test 3: two iterations, second one via the 5->2 loop
    iterate(3'd2);
    chk("it1_x", x_out, 16'h0080);
    chk("it1_y", y_out, 16'h0080);
    chk("it1_u", u_out, 16'h0100);
    chk("it1_cw", {15'd0, continue_while}, 16'd1);
    iterate(3'd6);
    chk("it2_x", x_out, 16'h0100);
    chk("it2_y", y_out, 16'h0100);
    chk("it2_u", u_out, 16'hFF80);
    chk("it2_cw", {15'd0, continue_while}, 16'd0);
    step();

    // Test 4: negative operand; load_x must also clear y
    load(4'b1000, 16'h0000);
    chk("ldx_clr_y", y_out, 16'h0000);
    load(4'b0100, 16'h0040);
    load(4'b0001, 16'hFF00);
    state = 3'd6;
    step();
    iterate(3'd6);
    chk("sgn_y", y_out, 16'hFFC0);
    chk("sgn_x", x_out, 16'h0040);
    chk("sgn_u", u_out, 16'hFF00);
    step();

    // Test 6: abort at cycle 5, then full step on re-entry
    state = 3'd2;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("ab_pre%0d", i + 1), {15'd0, compute_done}, 16'd0);
    end
    state = 3'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("ab_idle%0d", i), {15'd0, compute_done}, 16'd0);
    end
    state = 3'd2;
    wait_done("reentry");

    // Test 5: reset in cycle 8 of COMPUTE_2
    state = 3'd3;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b0;
    #1;
    chk("mrst_x", x_out, 16'h0000);
    chk("mrst_y", y_out, 16'h0000);
    chk("mrst_u", u_out, 16'h0000);
    chk("mrst_done", {15'd0, compute_done}, 16'd0);
    chk("mrst_cw", {15'd0, continue_while}, 16'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("mrst_hold%0d", i), {15'd0, compute_done}, 16'd0);
    end
    state = 3'd4;
    wait_done("post_rst");
    state = 3'd0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
